// File: rtl/dds_sweep_ctrl.sv
// Sweep/chirp controller feeding the DDS signed phase-increment offset.
// Steps from a latched start offset toward a stop offset with per-value dwell; one-shot, sawtooth or triangle.
module dds_sweep_ctrl #(
  parameter int PHASE_W = 10,
  parameter int DWELL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic signed [PHASE_W-1:0] delta_start,
  input  logic signed [PHASE_W-1:0] delta_stop,
  input  logic [PHASE_W-2:0]        step,
  input  logic [DWELL_W-1:0]        dwell,
  output logic signed [PHASE_W-1:0] phase_inc_delta,
  output logic                      busy,
  output logic                      sweep_done,
  output logic                      sweep_wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state_q;
  logic signed [PHASE_W-1:0]   out_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        wrap_q;
  logic [DWELL_W-1:0]          cnt_q;
  logic                        dir_q;

  logic [1:0]                  mode_q;
  logic signed [PHASE_W-1:0]   lat_start_q;
  logic signed [PHASE_W-1:0]   lat_stop_q;
  logic [PHASE_W-2:0]          step_q;
  logic [DWELL_W-1:0]          dwell_q;

  logic                        launch;
  logic                        init_dn;
  logic                        toward_stop;
  logic signed [PHASE_W-1:0]   ep;
  logic signed [PHASE_W-1:0]   ep_rev;
  logic signed [PHASE_W-1:0]   nxt_d;
  logic signed [PHASE_W-1:0]   rev_d;

  // One step from cur toward ep, computed one bit wider, clamped so it never passes ep.
  function automatic logic signed [PHASE_W-1:0] step_toward(
    input logic signed [PHASE_W-1:0] cur,
    input logic signed [PHASE_W-1:0] tgt,
    input logic                      down,
    input logic [PHASE_W-2:0]        stp
  );
    logic signed [PHASE_W:0] c;
    logic signed [PHASE_W:0] e;
    logic signed [PHASE_W:0] s;
    logic signed [PHASE_W:0] n;
    c = {cur[PHASE_W-1], cur};
    e = {tgt[PHASE_W-1], tgt};
    s = {2'b00, stp};
    n = down ? (c - s) : (c + s);
    if (down ? (n < e) : (n > e)) n = e;
    return n[PHASE_W-1:0];
  endfunction

  assign launch      = (state_q == IDLE) && start && !stop;
  assign init_dn     = lat_stop_q < lat_start_q;
  assign toward_stop = (dir_q == init_dn);
  assign ep          = toward_stop ? lat_stop_q : lat_start_q;
  assign ep_rev      = toward_stop ? lat_start_q : lat_stop_q;
  assign nxt_d       = step_toward(out_q, ep, dir_q, step_q);
  assign rev_d       = step_toward(out_q, ep_rev, ~dir_q, step_q);

  // Sweep configuration is sampled only at launch; it is don't-care while idle.
  always_ff @(posedge clk) begin
    if (launch) begin
      mode_q      <= mode;
      lat_start_q <= delta_start;
      lat_stop_q  <= delta_stop;
      step_q      <= (step == '0) ? {{(PHASE_W-2){1'b0}}, 1'b1} : step;
      dwell_q     <= dwell;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            out_q   <= delta_start;
            cnt_q   <= dwell;
            dir_q   <= (delta_stop < delta_start);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
          end else if (out_q != ep) begin
            out_q <= nxt_d;
            cnt_q <= dwell_q;
          end else begin
            case (mode_q)
              2'd1: begin
                out_q  <= lat_start_q;
                cnt_q  <= dwell_q;
                wrap_q <= 1'b1;
              end
              2'd2: begin
                dir_q  <= ~dir_q;
                out_q  <= rev_d;
                cnt_q  <= dwell_q;
                wrap_q <= 1'b1;
              end
              default: begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phase_inc_delta = out_q;
  assign busy            = busy_q;
  assign sweep_done      = done_q;
  assign sweep_wrap      = wrap_q;

endmodule
